// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// decoder/mux and its ERROR-response FSM.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       sel_unmapped,
    output logic       HREADYOUT_def,
    output logic       HRESP_def
);

    ds_state_e state_q, state_d;
    logic      err_req;

    assign err_req = HREADY && sel_unmapped &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (err_req) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = err_req ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // Outputs depend on state only, keeping HREADY free of a combinational loop.
    assign HREADYOUT_def = (state_q != DS_ERR1);
    assign HRESP_def     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite address decoder and slave-to-master response multiplexer with an
// integrated default slave for unmapped index values.
module ahb_lite_decode_mux
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned NUM_SLAVES = 6
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP
);

    localparam logic [IDX_W:0] NUM_S = (IDX_W+1)'(NUM_SLAVES);

    logic [IDX_W-1:0]        idx;
    logic                    mapped;
    logic [IDX_W-1:0]        dp_sel_q, dp_sel_d;
    logic                    dp_valid_q, dp_valid_d;
    logic                    hreadyout_def, hresp_def;
    logic [ADDR_W-IDX_W-1:0] unused_addr_bits;

    assign idx              = HADDR[ADDR_W-1 -: IDX_W];
    assign mapped           = ({1'b0, idx} < NUM_S);
    assign unused_addr_bits = HADDR[ADDR_W-IDX_W-1:0];

    always_comb begin
        HSEL = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx == i[IDX_W-1:0]) HSEL[i] = 1'b1;
        end
    end

    always_comb begin
        dp_sel_d   = dp_sel_q;
        dp_valid_d = dp_valid_q;
        if (HREADY) begin
            dp_sel_d   = idx;
            dp_valid_d = mapped;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_sel_q   <= '0;
            dp_valid_q <= 1'b0;
        end else begin
            dp_sel_q   <= dp_sel_d;
            dp_valid_q <= dp_valid_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = hreadyout_def;
        HRESP  = hresp_def;
        if (dp_valid_q) begin
            HREADY = 1'b1;
            HRESP  = HRESP_OKAY;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (dp_sel_q == i[IDX_W-1:0]) begin
                    HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HREADY        (HREADY),
        .HTRANS        (HTRANS),
        .sel_unmapped  (!mapped),
        .HREADYOUT_def (hreadyout_def),
        .HRESP_def     (hresp_def)
    );

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// Scoreboard bench: stimulus pushes the expected data-phase response of each
// transfer; a monitor pops and compares whenever a data phase completes.
module tb_ahb_lite_decode_mux;

    localparam int NS = 6;

    typedef struct {
        logic [31:0] d;
        logic        r;
        int          w;
    } exp_t;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [NS-1:0]    HSEL;
    logic [NS*32-1:0] HRDATA_S;
    logic [NS-1:0]    HREADYOUT_S;
    logic [NS-1:0]    HRESP_S;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b1;
    bit   rand_mode = 1'b1;

    // Simple slave stubs: fixed data, configurable wait states and error.
    logic [31:0]      cfg_data[NS];
    int               cfg_waits[NS];
    logic [NS-1:0]    cfg_err;
    logic [NS-1:0]    act_q;
    int               cnt_q[NS];
    logic [NS*32-1:0] stub_data, rnd_data;
    logic [NS-1:0]    stub_rdy, stub_resp, rnd_rdy, rnd_resp;

    always #5 HCLK = ~HCLK;

    ahb_lite_decode_mux #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .IDX_W      (3),
        .NUM_SLAVES (NS)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always @(posedge HCLK) begin
        for (int i = 0; i < NS; i++) begin
            if (HRESET) begin
                act_q[i] <= 1'b0;
                cnt_q[i] <= 0;
            end else if (HREADY) begin
                act_q[i] <= HSEL[i] && HTRANS[1];
                cnt_q[i] <= cfg_waits[i];
            end else if (cnt_q[i] > 0) begin
                cnt_q[i] <= cnt_q[i] - 1;
            end
        end
        rnd_data <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rnd_rdy  <= NS'($urandom);
        rnd_resp <= NS'($urandom);
    end

    always_comb begin
        stub_data = '0;
        stub_rdy  = '1;
        stub_resp = '0;
        for (int i = 0; i < NS; i++) begin
            stub_data[i*32 +: 32] = cfg_data[i];
            stub_rdy[i]           = !(act_q[i] && (cnt_q[i] != 0));
            stub_resp[i]          = act_q[i] && cfg_err[i];
        end
    end

    assign HRDATA_S    = rand_mode ? rnd_data : stub_data;
    assign HREADYOUT_S = rand_mode ? rnd_rdy  : stub_rdy;
    assign HRESP_S     = rand_mode ? rnd_resp : stub_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a data phase completes on every cycle with HREADY high.
    int   waits = 0;
    logic wait_resp = 1'b0;
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (HRESET) begin
                waits = 0;
            end else if (!HREADY) begin
                waits++;
                wait_resp = HRESP;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got data %h with empty queue at %0t", HRDATA, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("hrdata", HRDATA, e.d);
                    chk("hresp", 32'(HRESP), 32'(e.r));
                    chk("wait_states", 32'(waits), 32'(e.w));
                    if (e.w > 0) chk("wait_hresp", 32'(wait_resp), 32'(e.r));
                end
                waits = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic [NS-1:0] hs,
                         input logic [31:0] d, input logic r, input int w, input bit push);
        logic rdy;
        HADDR  = a;
        HTRANS = t;
        if (push) exp_q.push_back('{d: d, r: r, w: w});
        for (int n = 0; ; n++) begin
            @(negedge HCLK);
            chk("hsel", 32'(HSEL), 32'(hs));
            rdy = HREADY;
            @(posedge HCLK);
            #1;
            if (rdy) break;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: HREADY stayed 0, expected 1 within 20 cycles");
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge HCLK);
        #2 rand_mode = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_data  = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hDEAD_BEEF,
                      32'hC3C3_0003, 32'h4444_0004, 32'h5555_0005};
        cfg_waits = '{1, 0, 2, 1, 0, 0};
        cfg_err   = 6'b001000;
        HRESET    = 1'b1;
        HADDR     = 32'h4000_0000;
        HTRANS    = ahb_pkg::HTRANS_NONSEQ;

        @(negedge HCLK);
        chk("reset_hsel", 32'(HSEL), 32'h04);
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        exp_q.push_back('{d: 32'h0, r: 1'b0, w: 0});

        // Mapped read to slave 2 with two wait states.
        issue(32'h4000_0000, 2'b10, 6'b000100, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
        // Unmapped NONSEQ: two-cycle ERROR.
        issue(32'hE000_0000, 2'b10, 6'b000000, 32'h0, 1'b1, 1, 1'b1);
        // Unmapped IDLE: zero-wait OKAY.
        issue(32'hC000_0000, 2'b00, 6'b000000, 32'h0, 1'b0, 0, 1'b1);
        // Pipelined slave 0 (one wait) then slave 1.
        issue(32'h0000_0000, 2'b10, 6'b000001, 32'hA0A0_0000, 1'b0, 1, 1'b1);
        issue(32'h2000_0000, 2'b10, 6'b000010, 32'hB1B1_0001, 1'b0, 0, 1'b1);
        // Slave 3 returns its own two-cycle ERROR.
        issue(32'h6000_0000, 2'b10, 6'b001000, 32'hC3C3_0003, 1'b1, 1, 1'b1);
        // Back-to-back unmapped: ERR2 goes straight to ERR1.
        issue(32'hC000_0000, 2'b10, 6'b000000, 32'h0, 1'b1, 1, 1'b1);
        issue(32'hE000_0004, 2'b11, 6'b000000, 32'h0, 1'b1, 1, 1'b1);
        // Mapped IDLE to slave 5, unmapped BUSY, mapped NONSEQ to slave 4.
        issue(32'hA000_0000, 2'b00, 6'b100000, 32'h5555_0005, 1'b0, 0, 1'b1);
        issue(32'hE000_0000, 2'b01, 6'b000000, 32'h0, 1'b0, 0, 1'b1);
        issue(32'h8000_0000, 2'b10, 6'b010000, 32'h4444_0004, 1'b0, 0, 1'b1);

        // Reset while the default slave is in its first ERROR cycle.
        issue(32'hE000_0000, 2'b10, 6'b000000, 32'h0, 1'b1, 1, 1'b0);
        HRESET = 1'b1;
        HTRANS = 2'b00;
        HADDR  = 32'h0;
        exp_q.push_back('{d: 32'h0, r: 1'b0, w: 0});
        @(negedge HCLK);
        chk("err1_hready", 32'(HREADY), 32'h0);
        chk("err1_hresp", 32'(HRESP), 32'h1);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        issue(32'h0000_0000, 2'b00, 6'b000001, 32'hA0A0_0000, 1'b0, 0, 1'b1);

        HADDR  = 32'hE000_0000;
        HTRANS = 2'b00;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(negedge HCLK);
            #1;
        end
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
